// File: rtl/vga_timing.sv
// VGA raster timing generator: scans an h/v counter pair over the full frame
// and emits registered sync, display-enable, coordinates and frame strobe.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       de_d;
  logic       hs_d;
  logic       vs_d;
  logic       fs_d;

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  // Decode is taken from the pre-edge counters, giving one clock of latency.
  always_comb begin
    de_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_d = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_d = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= hs_d;
      vsync       <= vs_d;
      de          <= de_d;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance and a shrunken-frame instance
// driven together and compared against a position-from-edge-count model.
module tb_vga_timing;

  logic       clk;
  logic       rst;
  logic       en;

  logic       hs_b, vs_b, de_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, de_s, fs_s;
  logic [9:0] x_s, y_s;

  int vectors;
  int miscompares;
  int ecnt;

  localparam int SHA = 40, SHFP = 6, SHS = 10, SHBP = 8;
  localparam int SVA = 30, SVFP = 3, SVS = 2, SVBP = 5;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;
  localparam int SFRAME = SHT * SVT;

  vga_timing u_std (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .frame_start(fs_b)
  );

  vga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
  ) u_small (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs_s), .vsync(vs_s), .de(de_s),
    .x(x_s), .y(y_s), .frame_start(fs_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after cnt enabled edges since reset:
  // {hsync, vsync, de, x[9:0], y[9:0], frame_start}
  function automatic logic [23:0] expv(input int cnt,
    input int ha, input int hfp, input int hs, input int hbp,
    input int va, input int vfp, input int vs, input int vbp);
    int ht, vt, p, px, py;
    logic h, v, d, f;
    if (cnt == 0) return {3'b110, 10'd0, 10'd0, 1'b0};
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p  = (cnt - 1) % (ht * vt);
    px = p % ht;
    py = p / ht;
    h  = !(px >= ha + hfp && px < ha + hfp + hs);
    v  = !(py >= va + vfp && py < va + vfp + vs);
    d  = (px < ha) && (py < va);
    f  = (p == 0);
    return {h, v, d, 10'(px), 10'(py), f};
  endfunction

  function automatic logic [23:0] exp_std(input int cnt);
    return expv(cnt, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [23:0] exp_small(input int cnt);
    return expv(cnt, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP);
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs,
                     input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h (edge %0d)",
             tag, obs, exp, ecnt);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_std"}, {hs_b, vs_b, de_b, x_b, y_b, fs_b}, exp_std(ecnt));
    chk({tag, "_small"}, {hs_s, vs_s, de_s, x_s, y_s, fs_s},
        exp_small(ecnt));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst && en) ecnt++;
    #1;
    check_all("scan");
  endtask

  initial begin : stim
    int dcnt, fcnt, hcnt, maxx, maxy, n;
    logic [23:0] e;
    vectors = 0;
    miscompares = 0;
    ecnt = 0;
    rst = 1'b1;
    en  = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_all("reset");
    repeat (3) step();

    rst = 1'b1;
    en  = 1'b1;
    step();
    chk_int("first_x", int'(x_b), 0);
    chk_int("first_y", int'(y_b), 0);
    chk_int("first_de", int'(de_b), 1);
    chk_int("first_fs", int'(fs_b), 1);
    chk_int("first_syncs", int'({hs_b, vs_b}), 3);
    step();
    chk_int("second_x", int'(x_b), 1);
    chk_int("second_fs", int'(fs_b), 0);

    dcnt = 0; fcnt = 0; maxx = 0; maxy = 0;
    repeat (2 * SFRAME) begin
      step();
      dcnt += int'(de_s);
      fcnt += int'(fs_s);
      if (int'(x_s) > maxx) maxx = int'(x_s);
      if (int'(y_s) > maxy) maxy = int'(y_s);
    end
    chk_int("de_cnt_2frames", dcnt, 2 * SVA * SHA);
    chk_int("fs_cnt_2frames", fcnt, 2);
    chk_int("max_x", maxx, SHT - 1);
    chk_int("max_y", maxy, SVT - 1);

    dcnt = 0; hcnt = 0;
    repeat (800) begin
      step();
      dcnt += int'(de_b);
      hcnt += int'(!hs_b);
    end
    chk_int("std_line_de", dcnt, 640);
    chk_int("std_line_hsync", hcnt, 96);

    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    step();

    repeat (1500) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;

    n = 0;
    e = exp_small(ecnt);
    while (!(int'(e[20:11]) == SHA + SHFP + 2 &&
             int'(e[10:1]) == SVA + SVFP + 1) && n < 4000) begin
      step();
      e = exp_small(ecnt);
      n++;
    end
    chk_int("reach_mid_sync", int'(n < 4000), 1);
    chk_int("in_sync_h", int'(hs_s), 0);
    chk_int("in_sync_v", int'(vs_s), 0);
    #3 rst = 1'b0;
    #1 ecnt = 0;
    check_all("async_rst");
    chk_int("async_rst_hs", int'(hs_s), 1);
    step();
    step();
    rst = 1'b1;
    step();
    chk_int("restart_fs", int'(fs_s), 1);
    chk_int("restart_x", int'(x_s), 0);

    repeat (4) begin
      repeat ($urandom_range(50, 500)) begin
        en = ($urandom_range(0, 7) != 0);
        step();
      end
      #2 rst = 1'b0;
      #1 ecnt = 0;
      check_all("rand_rst");
      step();
      rst = 1'b1;
      en  = 1'b1;
    end
    repeat (200) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
